// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus between the PC sequencer (master) and the IM (slave).
// im_addr is the current PC; im_ack marks returned data and completes the request.
interface pc_fetch_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                im_req;
  logic [PC_WIDTH-1:0] im_addr;
  logic                im_ack;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and IM fetch controller: chooses the next PC, runs the IM
// handshake, drains in-flight fetches on redirect and keeps the saved exception PC.
module pc_fetch_ctrl #(
  parameter int                 PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [PC_WIDTH-1:0] EXC_VEC   = 32'h0000_0700
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                pc_wr,
  output logic [PC_WIDTH-1:0] npc,
  pc_fetch_ctrl_if.master     im,
  output logic                ir_valid,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                exc_req,
  input  logic [PC_WIDTH-1:0] exc_pc,
  input  logic                rfi,
  output logic [PC_WIDTH-1:0] epc
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [PC_WIDTH-1:0] redir_pc;
  logic [PC_WIDTH-1:0] redir_pc_next;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] target;
  logic                redir;
  logic                im_req_c;

  assign pc_plus4 = pc + PC_WIDTH'(4);
  assign redir    = exc_req | rfi | br_taken;
  assign target   = exc_req ? EXC_VEC : (rfi ? epc : br_target);

  assign im.im_addr = pc;
  assign im.im_req  = im_req_c;

  always_comb begin
    pc_wr         = 1'b0;
    npc           = pc_plus4;
    im_req_c      = 1'b0;
    ir_valid      = 1'b0;
    state_next    = state;
    redir_pc_next = redir_pc;

    if (rst) begin
      npc        = RESET_VEC;
      state_next = BOOT;
    end else begin
      case (state)
        BOOT: begin
          pc_wr      = 1'b1;
          npc        = RESET_VEC;
          state_next = FETCH;
        end

        FETCH: begin
          im_req_c = 1'b1;
          if (!im.im_ack) begin
            // The request cannot be withdrawn, so a redirect waits for the ack in DRAIN.
            if (redir) begin
              redir_pc_next = target;
              state_next    = DRAIN;
            end
          end else if (redir) begin
            pc_wr = 1'b1;
            npc   = target;
          end else begin
            ir_valid = 1'b1;
            if (stall) begin
              state_next = HOLD;
            end else begin
              pc_wr = 1'b1;
            end
          end
        end

        HOLD: begin
          if (redir) begin
            pc_wr      = 1'b1;
            npc        = target;
            state_next = FETCH;
          end else begin
            ir_valid = 1'b1;
            if (!stall) begin
              pc_wr      = 1'b1;
              state_next = FETCH;
            end
          end
        end

        DRAIN: begin
          im_req_c = 1'b1;
          if (redir) begin
            redir_pc_next = target;
          end
          if (im.im_ack) begin
            pc_wr      = 1'b1;
            npc        = redir ? target : redir_pc;
            state_next = FETCH;
          end
        end

        default: begin
          state_next = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      epc      <= '0;
      redir_pc <= '0;
    end else begin
      state    <= state_next;
      redir_pc <= redir_pc_next;
      if (exc_req && state != BOOT) begin
        epc <= exc_pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each driven cycle pushes its expected outputs,
// which are popped and compared on the following falling edge.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_wr;
  logic [31:0] npc;
  logic        ir_valid;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        rfi;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_epc;

  typedef struct {
    string       tag;
    logic        wr;
    logic [31:0] npc;
    logic        req;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];

  pc_fetch_ctrl_if #(.PC_WIDTH(32)) im_bus ();

  pc_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .pc_wr     (pc_wr),
    .npc       (npc),
    .im        (im_bus.master),
    .ir_valid  (ir_valid),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .exc_req   (exc_req),
    .exc_pc    (exc_pc),
    .rfi       (rfi),
    .epc       (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The bench owns the PC register that the controller sequences.
  initial pc = 32'h0;
  always @(posedge clk) begin
    if (pc_wr) pc <= npc;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit r, input bit ack, input bit stl,
                               input bit b, input bit e, input bit f, input logic [31:0] tgt,
                               input bit x_wr, input logic [31:0] x_npc, input bit x_req,
                               input bit x_valid, input logic [31:0] x_addr);
    exp_t item;
    @(posedge clk);
    #1;
    rst           = r;
    im_bus.im_ack = ack;
    stall         = stl;
    br_taken      = b;
    exc_req       = e;
    rfi           = f;
    br_target     = tgt;
    exc_pc        = tgt;
    item.tag   = tag;
    item.wr    = x_wr;
    item.npc   = x_npc;
    item.req   = x_req;
    item.valid = x_valid;
    item.addr  = x_addr;
    item.epc   = exp_epc;
    sb.push_back(item);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t item;
      item = sb.pop_front();
      checkOutput({item.tag, ".pc_wr"},    32'(pc_wr),         32'(item.wr));
      checkOutput({item.tag, ".npc"},      npc,                item.npc);
      checkOutput({item.tag, ".im_req"},   32'(im_bus.im_req), 32'(item.req));
      checkOutput({item.tag, ".ir_valid"}, 32'(ir_valid),      32'(item.valid));
      checkOutput({item.tag, ".im_addr"},  im_bus.im_addr,     item.addr);
      checkOutput({item.tag, ".epc"},      epc,                item.epc);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst           = 1'b1;
    im_bus.im_ack = 1'b0;
    stall         = 1'b0;
    br_taken      = 1'b0;
    br_target     = 32'h0;
    exc_req       = 1'b0;
    exc_pc        = 32'h0;
    rfi           = 1'b0;
    exp_epc       = 32'h0;

    // Reset, boot and sequential fetch
    applyStimulus("rst0",   1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h3000, 0, 0, 32'h0);
    applyStimulus("rst1",   1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h3000, 0, 0, 32'h0);
    applyStimulus("boot",   0, 1, 0, 0, 0, 0, 32'h0, 1, 32'h3000, 0, 0, 32'h0);
    applyStimulus("seq0",   0, 1, 0, 0, 0, 0, 32'h0, 1, 32'h3004, 1, 1, 32'h3000);
    applyStimulus("seq1",   0, 1, 0, 0, 0, 0, 32'h0, 1, 32'h3008, 1, 1, 32'h3004);

    // Stall at 3008 for three cycles, then release
    applyStimulus("stl0",   0, 1, 1, 0, 0, 0, 32'h0, 0, 32'h300C, 1, 1, 32'h3008);
    applyStimulus("stl1",   0, 1, 1, 0, 0, 0, 32'h0, 0, 32'h300C, 0, 1, 32'h3008);
    applyStimulus("stl2",   0, 1, 1, 0, 0, 0, 32'h0, 0, 32'h300C, 0, 1, 32'h3008);
    applyStimulus("stlrel", 0, 1, 0, 0, 0, 0, 32'h0, 1, 32'h300C, 0, 1, 32'h3008);

    // Branch while the fetch at 300C waits for its ack
    applyStimulus("brw0",   0, 0, 0, 1, 0, 0, 32'h4000, 0, 32'h3010, 1, 0, 32'h300C);
    applyStimulus("brw1",   0, 0, 0, 0, 0, 0, 32'h0,    0, 32'h3010, 1, 0, 32'h300C);
    applyStimulus("brw2",   0, 0, 0, 0, 0, 0, 32'h0,    0, 32'h3010, 1, 0, 32'h300C);
    applyStimulus("brack",  0, 1, 0, 0, 0, 0, 32'h0,    1, 32'h4000, 1, 0, 32'h300C);
    applyStimulus("brnew",  0, 1, 0, 0, 0, 0, 32'h0,    1, 32'h4004, 1, 1, 32'h4000);

    // Exception beats rfi and branch; epc captures exc_pc
    applyStimulus("exc",    0, 1, 0, 1, 1, 1, 32'h3010, 1, 32'h0700, 1, 0, 32'h4004);
    exp_epc = 32'h3010;
    applyStimulus("hdl",    0, 1, 0, 0, 0, 0, 32'h0,    1, 32'h0704, 1, 1, 32'h0700);
    applyStimulus("rfi",    0, 1, 0, 0, 0, 1, 32'h0,    1, 32'h3010, 1, 0, 32'h0704);

    // A pending branch in DRAIN is overwritten by a later exception
    applyStimulus("dov0",   0, 0, 0, 1, 0, 0, 32'h4000, 0, 32'h3014, 1, 0, 32'h3010);
    applyStimulus("dov1",   0, 0, 0, 0, 1, 0, 32'h3020, 0, 32'h3014, 1, 0, 32'h3010);
    exp_epc = 32'h3020;
    applyStimulus("dovack", 0, 1, 0, 0, 0, 0, 32'h0,    1, 32'h0700, 1, 0, 32'h3010);

    // Redirect arriving together with the drain ack takes priority over the pending one
    applyStimulus("dsc0",   0, 0, 0, 1, 0, 0, 32'h4000, 0, 32'h0704, 1, 0, 32'h0700);
    applyStimulus("dscack", 0, 1, 0, 1, 0, 0, 32'h5000, 1, 32'h5000, 1, 0, 32'h0700);

    // Redirect out of HOLD kills the held instruction
    applyStimulus("hr0",    0, 1, 1, 0, 0, 0, 32'h0,    0, 32'h5004, 1, 1, 32'h5000);
    applyStimulus("hrbr",   0, 0, 1, 1, 0, 0, 32'h6000, 1, 32'h6000, 0, 0, 32'h5000);
    applyStimulus("fwait",  0, 0, 1, 0, 0, 0, 32'h0,    0, 32'h6004, 1, 0, 32'h6000);

    // PC wraps modulo 2^32
    applyStimulus("wrbr",   0, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0, 32'h6000);
    applyStimulus("wrap",   0, 1, 0, 0, 0, 0, 32'h0,    1, 32'h0000_0000, 1, 1, 32'hFFFF_FFFC);

    // Reset while draining, then boot ignores a stray exception
    applyStimulus("rdr0",   0, 0, 0, 1, 0, 0, 32'h4000, 0, 32'h0004, 1, 0, 32'h0);
    applyStimulus("rdrst",  1, 1, 0, 0, 0, 0, 32'h0,    0, 32'h3000, 0, 0, 32'h0);
    exp_epc = 32'h0;
    applyStimulus("rboot",  0, 1, 0, 0, 1, 0, 32'h1234, 1, 32'h3000, 0, 0, 32'h0);
    applyStimulus("rseq",   0, 1, 0, 0, 0, 0, 32'h0,    1, 32'h3004, 1, 1, 32'h3000);

    @(negedge clk);
    #1;
    checkOutput("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the PC register and the instruction-memory fetch port of the PowerPC core.
- Decides each cycle whether the PC is written and with what: reset vector, exception vector, rfi return address, branch target, or PC+4.
- Handles the IM req/ack handshake and flushes a fetch that is in flight when a redirect arrives.
- Keeps the saved exception PC (SRR0 equivalent) used by rfi.

Parameters:
- PC_WIDTH, 32, width of all address ports.
- RESET_VEC, 32'h0000_3000, first fetch address after reset (equal to IM_ADDR_BASE).
- EXC_VEC, 32'h0000_0700, exception handler entry address.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pc  in  PC_WIDTH  current value of the PC register
- pc_wr  out  1  PC register write enable
- npc  out  PC_WIDTH  next-PC value for the PC register
- im_req  out  1  instruction-memory request
- im_addr  out  PC_WIDTH  fetch address; always equal to pc
- im_ack  in  1  IM data valid and request complete
- ir_valid  out  1  fetched instruction available to decode
- stall  in  1  decode cannot consume this cycle
- br_taken  in  1  resolved taken branch
- br_target  in  PC_WIDTH  branch target
- exc_req  in  1  exception request
- exc_pc  in  PC_WIDTH  PC of faulting instruction
- rfi  in  1  return-from-interrupt
- epc  out  PC_WIDTH  saved exception PC

Behaviour:
- Reset: while rst=1, sampled at posedge clk:
  - State becomes BOOT; epc=0; redir_pc=0.
  - Outputs: pc_wr=0, im_req=0, ir_valid=0, npc=RESET_VEC.
- States: BOOT, FETCH, HOLD, DRAIN.
- Redirect ("redir") = exc_req | rfi | br_taken. Target priority:
  - exc_req gives EXC_VEC.
  - else rfi gives epc (the value before this edge).
  - else br_taken gives br_target.
- Redirect acceptance:
  - exc_req is accepted in every non-BOOT state.
  - On acceptance, epc <= exc_pc at the clock edge.
  - If exc_req and rfi are both high, exc_req wins and epc is updated.
- BOOT: one cycle. pc_wr=1, npc=RESET_VEC, im_req=0, all inputs ignored, next state FETCH.
- FETCH: im_req=1, im_addr=pc.
  - im_ack=0 and redir=0: hold. stall has no effect.
  - im_ack=0 and redir=1: redir_pc <= target, go to DRAIN, pc_wr=0. im_req stays asserted, address stable (no cancel on the IM bus).
  - im_ack=1 and redir=1: ir_valid=0 (instruction killed), pc_wr=1, npc=target, stay FETCH.
  - im_ack=1, redir=0, stall=0: ir_valid=1, pc_wr=1, npc=pc+4, stay FETCH.
  - im_ack=1, redir=0, stall=1: ir_valid=1, pc_wr=0, go to HOLD.
- HOLD: im_req=0, ir_valid=1.
  - redir=1: ir_valid=0, pc_wr=1, npc=target, go to FETCH.
  - stall=0: pc_wr=1, npc=pc+4, go to FETCH.
  - stall=1: remain in HOLD.
- DRAIN: im_req=1, ir_valid=0 always.
  - A new redir in DRAIN overwrites redir_pc (newest wins).
  - On im_ack: pc_wr=1. npc is the target of a same-cycle redir if present, otherwise redir_pc. Go to FETCH.
- Handshake timing:
  - A consumed instruction is ir_valid & !stall.
  - After each PC write, the next im_req uses the new pc on the following cycle; fetch latency is 1 cycle minimum.
- npc when pc_wr=0: pc+4.
- Arithmetic: pc+4 is modulo 2^PC_WIDTH, so 32'hFFFF_FFFC wraps to 0.
- Reset mid-fetch: the outstanding im_ack is ignored and the next state is BOOT. The IM slave must tolerate req dropping.
- im_addr=pc combinationally; pc_wr is asserted at most once per cycle.

Test Plan:
- Boot and sequential fetch: reset 2 cycles, release, im_ack tied to 1, stall=0.
  - Cycle 1: pc_wr=1, npc=3000.
  - Then pc_wr=1 each cycle with npc=3004, 3008, 300C; ir_valid=1 from cycle 2.
- Stall: at pc=3008, hold stall=1 for 3 cycles with ack=1.
  - State HOLD; ir_valid=1; pc_wr=0 for 3 cycles.
  - stall drop gives npc=300C.
- Branch during slow fetch: im_ack delayed 3 cycles; br_taken=1, br_target=4000 in the first wait cycle.
  - im_req stays high with im_addr unchanged.
  - On ack: ir_valid=0, npc=4000.
  - Next im_addr=4000.
- Exception beats branch: exc_req, br_taken and rfi all set, exc_pc=3010, ack=1.
  - npc=0700; epc=3010 next cycle.
  - Later rfi alone gives npc=3010.
- DRAIN overwrite: branch to 4000 pends, then exc_req before ack.
  - At ack: npc=0700.
- Wrap and reset mid-op:
  - pc=FFFF_FFFC with ack gives npc=0.
  - Assert rst while in DRAIN: pc_wr=0 and im_req=0 during reset; after release, BOOT gives npc=3000.
